stream_rr_arbiter: RTL and testbench
====================================

Name: stream_rr_arbiter

Overview:
- Shares one downstream valid/ready stream channel between N_PORTS upstream requesters using round-robin arbitration.
- Holds a grant for a whole packet (i_last-delimited) and registers the output beat: one register stage, ready passed through.
- Sits in front of a single skid buffer or datapath sink that several producers must reach.

Parameters:
- N_PORTS, 4: number of requesters, 2..16.
- WIDTH, 8: data width per beat.
- SRC_W, $clog2(N_PORTS) (localparam): width of the source index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_data  in  N_PORTS*WIDTH  requester data, port k at bits [k*WIDTH +: WIDTH].
- i_valid  in  N_PORTS  requester valid, one bit per port.
- i_last  in  N_PORTS  requester end-of-packet flag.
- o_ready  out  N_PORTS  ready back to each requester.
- o_data  out  WIDTH  registered output data.
- o_valid  out  1  registered output valid.
- o_last  out  1  registered output last flag.
- o_src  out  SRC_W  index of the port that produced the current output beat.
- i_ready  in  1  downstream ready.

Behaviour:
- Reset (rst low, asynchronous): o_valid=0, o_data=0, o_last=0, o_src=0, rr_ptr=0, state=ARB_IDLE, lock_idx=0. All o_ready bits are 0 while rst is low.
- Output stage:
  - can_accept = !o_valid || i_ready.
  - A beat leaves when o_valid && i_ready.
  - The stage loads on an upstream transfer. If no transfer happens and i_ready is high, o_valid clears.
  - o_data, o_last and o_src hold while o_valid && !i_ready.
- Latency: a beat accepted in cycle t is presented at the output in cycle t+1. Throughput is 1 beat/cycle when i_ready is held high.
- Grant:
  - In ARB_IDLE, grant is the first k with i_valid[k]=1, searching rr_ptr, rr_ptr+1, ... mod N_PORTS. If no valid bit is set, there is no grant.
  - In ARB_LOCK, grant = lock_idx regardless of the valid bits.
- o_ready[k] = rst && can_accept && grant valid && k==grant. At most one o_ready bit is ever high.
- Transfer on port g: i_valid[g] && o_ready[g]. The stage loads i_data[g], i_last[g] and src=g.
- State machine:
  - ARB_IDLE, transfer with i_last=0: go to ARB_LOCK, lock_idx=g.
  - ARB_IDLE, transfer with i_last=1 (single-beat packet): stay in ARB_IDLE, rr_ptr=(g+1) mod N_PORTS.
  - ARB_LOCK, transfer with i_last=1: go to ARB_IDLE, rr_ptr=(lock_idx+1) mod N_PORTS.
  - ARB_LOCK, otherwise: stay in ARB_LOCK; other ports are stalled even if valid.
- rr_ptr wraps from N_PORTS-1 to 0. rr_ptr changes only at packet end.
- Locked requester drops i_valid mid-packet: grant is held and no other port is served.
- Downstream backpressure: o_ready is deasserted only while o_valid && !i_ready. No beats are lost or duplicated.
- Reset mid-packet: the packet is truncated, the output register is cleared, and arbitration restarts from port 0.

Optional Feature:
- Macro: STREAM_ARB_PKT_LOCK_EN.
- Defined: packet locking as described above.
- Undefined:
  - ARB_LOCK is never entered; arbitration happens on every beat.
  - rr_ptr=(g+1) mod N_PORTS after every transfer.
  - i_last is forwarded to o_last only, with no effect on grant.

Decomposition:
- Package stream_arb_pkg:
  - arb_state_t enum {ARB_IDLE, ARB_LOCK};
  - function src_width(n) used for SRC_W.
- Sub-module rr_pick:
  - purely combinational; inputs req[N_PORTS] and ptr[SRC_W];
  - outputs gnt_valid and gnt_idx (first set bit at or after ptr, with wrap).
- The top level holds the FSM, rr_ptr, lock_idx and the output register.

Test Plan:
1. Reset mid-packet:
   - stimulus: rst low while port 1 is locked and o_valid=1;
   - response: o_valid=0 and o_ready=0000 immediately; after release, a new request from port 0 is granted first.
2. Fairness:
   - stimulus: N_PORTS=4, i_ready=1, all ports valid with single-beat packets (i_last=1), data=k;
   - response: o_src sequence 0,1,2,3,0,... and o_data matches, each beat one cycle after acceptance.
3. Packet lock:
   - stimulus: port 2 sends 3 beats (last on beat 3) while port 0 is also valid;
   - response: three consecutive beats with o_src=2, then o_src=0; o_ready[0]=0 throughout the packet.
4. Backpressure:
   - stimulus: i_ready=0 for 3 cycles while o_valid=1 with data 0xA5;
   - response: o_data holds 0xA5, all o_ready bits are 0, no beat is lost once i_ready returns.
5. Wrap and sparse requests:
   - stimulus: rr_ptr=3, only port 1 valid;
   - response: port 1 is granted, then rr_ptr=2.
6. Lock macro off:
   - stimulus: STREAM_ARB_PKT_LOCK_EN undefined, ports 0 and 1 both send 2-beat packets;
   - response: o_src sequence 0,1,0,1 (beats interleave).

Source files
------------

// File: rtl/stream_arb_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
// Provides the arbiter FSM state encoding and the source-index width function.
package stream_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping from N_PORTS-1 back to 0.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter  int N_PORTS = 4,
  localparam int SRC_W   = src_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic               gnt_valid,
  output logic [SRC_W-1:0]   gnt_idx
);

  localparam logic [SRC_W:0] N_P = (SRC_W+1)'(N_PORTS);

  logic [SRC_W:0] cand;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      cand = {1'b0, ptr} + (SRC_W+1)'(i);
      if (cand >= N_P) cand = cand - N_P;
      if (req[cand[SRC_W-1:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[SRC_W-1:0];
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// N-to-1 round-robin stream arbiter with a single registered output beat.
// Packet locking on i_last is enabled by defining STREAM_ARB_PKT_LOCK_EN.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int N_PORTS = 4,
  parameter  int WIDTH   = 8,
  localparam int SRC_W   = src_width(N_PORTS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS*WIDTH-1:0] i_data,
  input  logic [N_PORTS-1:0]       i_valid,
  input  logic [N_PORTS-1:0]       i_last,
  output logic [N_PORTS-1:0]       o_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_valid,
  output logic                     o_last,
  output logic [SRC_W-1:0]         o_src,
  input  logic                     i_ready
);

  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(N_PORTS - 1);

  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + 1'b1;
  endfunction

  arb_state_t       state, state_nx;
  logic [SRC_W-1:0] rr_ptr, ptr_nx;
  logic [SRC_W-1:0] lock_idx, lock_nx;

  logic             pick_valid;
  logic [SRC_W-1:0] pick_idx;
  logic             gnt_valid;
  logic [SRC_W-1:0] gnt_idx;
  logic             can_accept;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

  logic [WIDTH-1:0] data_p1;
  logic             last_p1;
  logic [SRC_W-1:0] src_p1;
  logic             vld_p1;

  rr_pick #(
    .N_PORTS (N_PORTS)
  ) u_pick (
    .req       (i_valid),
    .ptr       (rr_ptr),
    .gnt_valid (pick_valid),
    .gnt_idx   (pick_idx)
  );

  // A locked packet keeps its grant even while the owner has no valid beat.
  assign gnt_valid  = (state == ARB_LOCK) ? 1'b1     : pick_valid;
  assign gnt_idx    = (state == ARB_LOCK) ? lock_idx : pick_idx;
  assign can_accept = !vld_p1 || i_ready;
  assign sel_data   = i_data[gnt_idx*WIDTH +: WIDTH];
  assign sel_last   = i_last[gnt_idx];
  assign xfer       = i_valid[gnt_idx] && (|o_ready);

  always_comb begin
    o_ready = '0;
    if (rst && can_accept && gnt_valid) o_ready[gnt_idx] = 1'b1;
  end

  always_comb begin
    state_nx = state;
    ptr_nx   = rr_ptr;
    lock_nx  = lock_idx;
    if (xfer) begin
`ifdef STREAM_ARB_PKT_LOCK_EN
      case (state)
        ARB_IDLE: begin
          if (sel_last) begin
            ptr_nx = next_idx(gnt_idx);
          end else begin
            state_nx = ARB_LOCK;
            lock_nx  = gnt_idx;
          end
        end
        ARB_LOCK: begin
          if (sel_last) begin
            state_nx = ARB_IDLE;
            ptr_nx   = next_idx(lock_idx);
          end
        end
        default: state_nx = ARB_IDLE;
      endcase
`else
      state_nx = ARB_IDLE;
      ptr_nx   = next_idx(gnt_idx);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      rr_ptr   <= '0;
      lock_idx <= '0;
    end else begin
      state    <= state_nx;
      rr_ptr   <= ptr_nx;
      lock_idx <= lock_nx;
    end
  end

  // ---- stage p1: registered output beat ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
      src_p1  <= '0;
    end else if (xfer) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      last_p1 <= sel_last;
      src_p1  <= gnt_idx;
    end else if (i_ready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign o_valid = vld_p1;
  assign o_data  = data_p1;
  assign o_last  = last_p1;
  assign o_src   = src_p1;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Directed scoreboard bench for stream_rr_arbiter (N_PORTS=4, WIDTH=8);
// expectations follow STREAM_ARB_PKT_LOCK_EN when it is defined.
module tb_stream_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int BW = W + 1 + SW;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] i_data;
  logic [N-1:0]   i_valid;
  logic [N-1:0]   i_last;
  logic [N-1:0]   o_ready;
  logic [W-1:0]   o_data;
  logic           o_valid;
  logic           o_last;
  logic [SW-1:0]  o_src;
  logic           i_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic [BW-1:0] sb[$];

  always #5 clk = ~clk;

  stream_rr_arbiter #(
    .N_PORTS (N),
    .WIDTH   (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .i_data  (i_data),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .o_last  (o_last),
    .o_src   (o_src),
    .i_ready (i_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input bit l, input int s);
    sb.push_back({W'(d), l, SW'(s)});
  endtask

  task automatic drive(input int port, input int d, input bit v, input bit l);
    i_data[port*W +: W] = W'(d);
    i_valid[port]       = v;
    i_last[port]        = l;
  endtask

  // Every beat that leaves the output stage is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst && o_valid && i_ready) begin
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_underflow observed beat data=%0h src=%0d expected none", o_data, o_src);
      end
      if (sb.size() != 0) begin
        logic [BW-1:0] exp;
        exp = sb.pop_front();
        n_checks++;
        assert ({o_data, o_last, o_src} === exp) else begin
          n_fail++;
          $error("FAIL out_beat observed data=%0h last=%0b src=%0d expected data=%0h last=%0b src=%0d",
                 o_data, o_last, o_src, exp[BW-1 -: W], exp[SW], exp[SW-1:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    i_ready = 1'b1;
    i_data  = '0;
    i_valid = '1;
    i_last  = '1;
    #12;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_src",   32'(o_src),   32'd0);
    chk("rst_last",  32'(o_last),  32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    i_valid = '0;
    tick();
    rst = 1'b1;

    // Fairness: all ports valid with single-beat packets, data = port index.
    for (int k = 0; k < N; k++) drive(k, k, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) push(i % N, 1'b1, i % N);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("fair_ready", 32'(o_ready), 32'(1 << (i % N)));
      tick();
      chk("fair_latency_src", 32'(o_src), 32'(i % N));
    end
    i_valid = '0;
    tick();
    chk("fair_drain", 32'(sb.size()), 32'd0);
    chk("fair_idle_valid", 32'(o_valid), 32'd0);
    tick();

    // Backpressure: 0xA5 held for three stalled cycles, then 0x3C follows.
    drive(0, 'hA5, 1'b1, 1'b1);
    push('hA5, 1'b1, 0);
    push('h3C, 1'b1, 1);
    #1;
    chk("bp_ready0", 32'(o_ready), 32'h1);
    tick();
    drive(0, 0, 1'b0, 1'b0);
    drive(1, 'h3C, 1'b1, 1'b1);
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_hold_data",  32'(o_data),  32'hA5);
      chk("bp_hold_valid", 32'(o_valid), 32'd1);
      chk("bp_stall_ready", 32'(o_ready), 32'd0);
      tick();
    end
    i_ready = 1'b1;
    #1;
    chk("bp_ready1", 32'(o_ready), 32'h2);
    tick();
    drive(1, 0, 1'b0, 1'b0);
    tick();
    tick();
    chk("bp_drain", 32'(sb.size()), 32'd0);

    // Wrap and sparse requests: move rr_ptr to 3, then only port 1 valid.
    drive(2, 'h77, 1'b1, 1'b1);
    push('h77, 1'b1, 2);
    #1;
    chk("wrap_ready2", 32'(o_ready), 32'h4);
    tick();
    drive(2, 0, 1'b0, 1'b0);
    drive(1, 'h61, 1'b1, 1'b1);
    push('h61, 1'b1, 1);
    #1;
    chk("sparse_ready1", 32'(o_ready), 32'h2);
    tick();
    // rr_ptr must now be 2: with ports 1 and 2 valid, port 2 goes first.
    drive(1, 'h62, 1'b1, 1'b1);
    drive(2, 'h72, 1'b1, 1'b1);
    push('h72, 1'b1, 2);
    push('h62, 1'b1, 1);
    #1;
    chk("ptr2_ready2", 32'(o_ready), 32'h4);
    tick();
    drive(2, 0, 1'b0, 1'b0);
    #1;
    chk("ptr2_ready1", 32'(o_ready), 32'h2);
    tick();
    drive(1, 0, 1'b0, 1'b0);
    tick();
    tick();
    chk("wrap_drain", 32'(sb.size()), 32'd0);

    // Two 2-beat packets from ports 0 and 1, rr_ptr at 2.
    drive(0, 'h10, 1'b1, 1'b0);
    drive(1, 'h20, 1'b1, 1'b0);
`ifdef STREAM_ARB_PKT_LOCK_EN
    push('h10, 1'b0, 0);
    push('h11, 1'b1, 0);
    push('h20, 1'b0, 1);
    push('h21, 1'b1, 1);
    #1; chk("pkt_ready_a", 32'(o_ready), 32'h1);
    tick();
    drive(0, 'h11, 1'b1, 1'b1);
    #1; chk("pkt_ready_b", 32'(o_ready), 32'h1);
    tick();
    drive(0, 0, 1'b0, 1'b0);
    #1; chk("pkt_ready_c", 32'(o_ready), 32'h2);
    tick();
    drive(1, 'h21, 1'b1, 1'b1);
    #1; chk("pkt_ready_d", 32'(o_ready), 32'h2);
    tick();
    drive(1, 0, 1'b0, 1'b0);
`else
    push('h10, 1'b0, 0);
    push('h20, 1'b0, 1);
    push('h11, 1'b1, 0);
    push('h21, 1'b1, 1);
    #1; chk("ilv_ready_a", 32'(o_ready), 32'h1);
    tick();
    drive(0, 'h11, 1'b1, 1'b1);
    #1; chk("ilv_ready_b", 32'(o_ready), 32'h2);
    tick();
    drive(1, 'h21, 1'b1, 1'b1);
    #1; chk("ilv_ready_c", 32'(o_ready), 32'h1);
    tick();
    drive(0, 0, 1'b0, 1'b0);
    #1; chk("ilv_ready_d", 32'(o_ready), 32'h2);
    tick();
    drive(1, 0, 1'b0, 1'b0);
`endif
    tick();
    tick();
    chk("two_pkt_drain", 32'(sb.size()), 32'd0);

`ifdef STREAM_ARB_PKT_LOCK_EN
    // Port 2 holds the grant for 3 beats (with a valid gap) while port 0 waits.
    drive(0, 'h40, 1'b1, 1'b1);
    drive(2, 'h50, 1'b1, 1'b0);
    push('h50, 1'b0, 2);
    push('h51, 1'b0, 2);
    push('h52, 1'b1, 2);
    push('h40, 1'b1, 0);
    #1; chk("lock_beat0", 32'(o_ready), 32'h4);
    tick();
    drive(2, 'h51, 1'b0, 1'b0);
    #1; chk("lock_gap_hold", 32'(o_ready), 32'h4);
    tick();
    drive(2, 'h51, 1'b1, 1'b0);
    #1; chk("lock_beat1", 32'(o_ready), 32'h4);
    tick();
    drive(2, 'h52, 1'b1, 1'b1);
    #1; chk("lock_beat2", 32'(o_ready), 32'h4);
    tick();
    drive(2, 0, 1'b0, 1'b0);
    #1; chk("lock_then_port0", 32'(o_ready), 32'h1);
    tick();
    drive(0, 0, 1'b0, 1'b0);
    tick();
    tick();
    chk("lock_drain", 32'(sb.size()), 32'd0);
`endif

    // Reset mid-packet: port 1 first beat is stalled in the output register.
    drive(1, 'h90, 1'b1, 1'b0);
    #1;
    chk("rm_ready1", 32'(o_ready), 32'h2);
    tick();
    i_ready = 1'b0;
    drive(0, 'hA0, 1'b1, 1'b1);
    drive(3, 'hB0, 1'b1, 1'b1);
    drive(1, 'h91, 1'b1, 1'b1);
    #1;
    chk("rm_valid_pre", 32'(o_valid), 32'd1);
    rst = 1'b0;
    #1;
    chk("rm_valid_cleared", 32'(o_valid), 32'd0);
    chk("rm_data_cleared",  32'(o_data),  32'd0);
    chk("rm_ready_low",     32'(o_ready), 32'd0);
    tick();
    rst     = 1'b1;
    i_ready = 1'b1;
    push('hA0, 1'b1, 0);
    #1;
    chk("rm_restart_port0", 32'(o_ready), 32'h1);
    tick();
    i_valid = '0;
    tick();
    tick();
    chk("rm_drain", 32'(sb.size()), 32'd0);
    chk("rm_final_valid", 32'(o_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
